// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the access-size encodings, the responder state enum and the
// width of the wait-state counter.
package data_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Ports:
//   size        in  2   access size (byte / halfword / word / illegal)
//   addr_lo     in  2   low byte-address bits selecting the lane
//   is_unsigned in  1   zero-extend sub-word loads
//   wdata       in  32  raw store data (low bits used for sub-word stores)
//   rword       in  32  full memory word being read
//   wmask       out 4   byte lanes to write
//   wdata_lane  out 32  store data replicated into every candidate lane
//   rdata_ext   out 32  selected lane, sign- or zero-extended
//   misalign    out 1   halfword on odd address or word not 4-byte aligned
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction of the read word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rword[7:0];
            2'b01:   byte_s = rword[15:8];
            2'b10:   byte_s = rword[23:16];
            2'b11:   byte_s = rword[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Write mask, replicated write data, misalignment and load extension per size.
    always_comb begin
        wmask      = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        misalign   = 1'b0;
        case (size)
            SIZE_B: begin
                wmask      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = is_unsigned ? {24'h00_0000, byte_s}
                                         : {{24{byte_s[7]}}, byte_s};
            end
            SIZE_H: begin
                wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'h0000, half_s}
                                         : {{16{half_s[15]}}, half_s};
                misalign   = addr_lo[0];
            end
            SIZE_W: begin
                wmask      = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
                misalign   = (addr_lo != 2'b00);
            end
            default: begin
                wmask      = 4'b0000;
                wdata_lane = 32'h0000_0000;
                rdata_ext  = 32'h0000_0000;
                misalign   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory load/store interface, with a
// programmable number of wait states before each one-cycle response.
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid            one-cycle response strobe
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              misaligned, out of range or illegal size
// The storage array is named memory[] so benches can inspect it.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] memory [DEPTH];

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic        we_r, uns_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;

    logic        req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0] rsp_rdata_r;

    logic        accept_s, enter_resp_s, wr_en_s, err_s, oor_s, misalign_s;
    logic        cur_we_s, cur_uns_s;
    logic [1:0]  cur_size_s;
    logic [31:0] cur_addr_s, cur_wdata_s, rword_s, rdata_ext_s, wdata_lane_s;
    logic [29:0] idx_s;
    logic [AW-1:0] widx_s;
    logic [3:0]  wmask_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    assign accept_s = req_valid && req_ready_r;

    // Access datapath source: with zero wait states the access happens on the
    // accept edge itself, before the capture registers hold the request.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s    = req_we;
            cur_size_s  = req_size;
            cur_uns_s   = req_unsigned;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_size_s  = size_r;
            cur_uns_s   = uns_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    assign idx_s   = cur_addr_s[31:2];
    assign widx_s  = idx_s[AW-1:0];
    assign oor_s   = ({2'b00, idx_s} >= 32'(DEPTH));
    assign rword_s = memory[widx_s];

    mem_lane_align u_align (
        .size        (cur_size_s),
        .addr_lo     (cur_addr_s[1:0]),
        .is_unsigned (cur_uns_s),
        .wdata       (cur_wdata_s),
        .rword       (rword_s),
        .wmask       (wmask_s),
        .wdata_lane  (wdata_lane_s),
        .rdata_ext   (rdata_ext_s),
        .misalign    (misalign_s)
    );

    assign err_s        = misalign_s || oor_s || (cur_size_s == SIZE_X);
    assign enter_resp_s = (state_s == RESP) && (state_r != RESP);
    assign wr_en_s      = enter_resp_s && cur_we_s && !err_s;

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (WAIT_CYCLES == 0) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, counter, request capture and registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == IDLE);
            rsp_valid_r <= enter_resp_s;
            if (accept_s) begin
                we_r    <= req_we;
                size_r  <= req_size;
                uns_r   <= req_unsigned;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (enter_resp_s) begin
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (err_s || cur_we_s) ? 32'h0000_0000 : rdata_ext_s;
            end else begin
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    // Byte-lane store into the array. The array is never cleared, and the
    // reset_n gate keeps a request presented while in reset from committing.
    always_ff @(posedge clk) begin
        if (wr_en_s && reset_n) begin
            if (wmask_s[0]) memory[widx_s][7:0]   <= wdata_lane_s[7:0];
            if (wmask_s[1]) memory[widx_s][15:8]  <= wdata_lane_s[15:8];
            if (wmask_s[2]) memory[widx_s][23:16] <= wdata_lane_s[23:16];
            if (wmask_s[3]) memory[widx_s][31:24] <= wdata_lane_s[31:24];
        end
    end

endmodule
